seg_scan_ctrl: RTL and testbench

- Time-multiplexes NDIGITS BCD digits, plus a decimal point per digit, onto one shared combinational BCD-to-7-segment decoder and a common-segment display.
- Drives the decoder's value and dec inputs, a segment blank, and one-hot digit enables.
- Provides dead-time between digits (anti-ghosting), PWM brightness and leading-zero blanking.
- Accepts new display words through a valid/ready handshake, committed only at frame boundaries so the display never tears.

---
 rtl/seg_scan_ctrl.sv | 117 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: drives a shared BCD decoder and one-hot
// digit enables with dead-time, PWM brightness, leading-zero blanking and tear-free updates.
module seg_scan_ctrl #(
  parameter int NDIGITS    = 4,
  parameter int DEAD       = 16,
  parameter int BRIGHTBITS = 3,
  parameter int STEPBITS   = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [4*NDIGITS-1:0]   i_wr_data,
  input  logic [NDIGITS-1:0]     i_wr_dp,
  input  logic                   i_lzb,
  input  logic [BRIGHTBITS-1:0]  i_bright,
  output logic [3:0]             o_val,
  output logic                   o_dec,
  output logic                   o_blank,
  output logic [NDIGITS-1:0]     o_dig_en,
  output logic                   o_frame
);

  localparam int ONW  = BRIGHTBITS + STEPBITS;
  localparam int SLOT = DEAD + (1 << ONW);
  localparam int DCW  = $clog2(SLOT);
  localparam int DW   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [DCW-1:0] DC_LAST = DCW'(SLOT - 1);
  localparam logic [DCW-1:0] DC_DEAD = DCW'(DEAD);
  localparam logic [DW-1:0]  D_LAST  = DW'(NDIGITS - 1);

  logic [DCW-1:0]             dc;
  logic [DW-1:0]              d;
  logic [NDIGITS-1:0][3:0]    disp;
  logic [NDIGITS-1:0][3:0]    sh_data;
  logic [NDIGITS-1:0]         dp_r;
  logic [NDIGITS-1:0]         sh_dp;
  logic                       pending;
  logic [BRIGHTBITS-1:0]      br;

  logic slot_end;
  logic frame_end;
  logic accept;

  assign slot_end  = (dc == DC_LAST);
  assign frame_end = slot_end && (d == D_LAST);
  // Handshake: a word transfers on any cycle with i_wr_valid && o_wr_ready; the
  // source holds valid (and data) until then. Ready stays low while a word waits
  // in the shadow register for the next frame boundary.
  assign accept     = i_wr_valid && !pending;
  assign o_wr_ready = !pending;
  assign o_frame    = frame_end;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dc      <= '0;
      d       <= '0;
      disp    <= '0;
      dp_r    <= '0;
      sh_data <= '0;
      sh_dp   <= '0;
      pending <= 1'b0;
      br      <= '0;
    end else begin
      if (slot_end) begin
        dc <= '0;
        br <= i_bright;
        d  <= (d == D_LAST) ? '0 : d + 1'b1;
      end else begin
        dc <= dc + 1'b1;
      end
      // Commit and capture are exclusive: capture needs pending==0, commit needs pending==1.
      if (frame_end && pending) begin
        disp    <= sh_data;
        dp_r    <= sh_dp;
        pending <= 1'b0;
      end else if (accept) begin
        sh_data <= i_wr_data;
        sh_dp   <= i_wr_dp;
        pending <= 1'b1;
      end
    end
  end

  // lead_zero[k]: every nibble and dp from the top digit down to k is zero.
  logic [NDIGITS-1:0] lead_zero;
  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      run          = run & (disp[k] == 4'd0) & ~dp_r[k];
      lead_zero[k] = run;
    end
  end

  logic [ONW-1:0] off;
  logic           lit;
  logic           in_dead;
  logic           lz_blank;

  always_comb begin
    off      = ONW'(dc - DC_DEAD);
    in_dead  = (dc < DC_DEAD);
    lit      = (off[ONW-1:STEPBITS] < br);
    lz_blank = i_lzb && (d != '0) && lead_zero[d];
    o_val    = disp[d];
    o_dec    = dp_r[d];
    o_dig_en = '0;
    o_blank  = 1'b1;
    if (!in_dead && !lz_blank && lit) begin
      o_dig_en = NDIGITS'(1) << d;
      o_blank  = 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (2 digits, SLOT=10, frame=20) against a
// cycle-count based reference model plus directed expectations from the test plan.
module tb_seg_scan_ctrl;

  localparam int ND    = 2;
  localparam int DEAD  = 2;
  localparam int BB    = 2;
  localparam int SB    = 1;
  localparam int STEP  = 1 << SB;
  localparam int SLOT  = DEAD + (1 << (BB + SB));
  localparam int FRAME = ND * SLOT;
  localparam logic [9:0] RESET_VEC = 10'b1_0000_0_1_00_0;

  logic              clk = 1'b0;
  logic              i_rst_n;
  logic              i_wr_valid;
  logic              o_wr_ready;
  logic [4*ND-1:0]   i_wr_data;
  logic [ND-1:0]     i_wr_dp;
  logic              i_lzb;
  logic [BB-1:0]     i_bright;
  logic [3:0]        o_val;
  logic              o_dec;
  logic              o_blank;
  logic [ND-1:0]     o_dig_en;
  logic              o_frame;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIGITS(ND), .DEAD(DEAD), .BRIGHTBITS(BB), .STEPBITS(SB)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_data(i_wr_data), .i_wr_dp(i_wr_dp), .i_lzb(i_lzb), .i_bright(i_bright),
    .o_val(o_val), .o_dec(o_dec), .o_blank(o_blank), .o_dig_en(o_dig_en), .o_frame(o_frame)
  );

  // Reference model: time since reset plus the committed word, the waiting word and brightness.
  int          m_cyc;
  logic        m_pend;
  logic        m_acc;
  logic [7:0]  m_sh_data, m_data;
  logic [1:0]  m_sh_dp, m_dp;
  logic [1:0]  m_br;

  always @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_cyc <= 0; m_pend <= 1'b0; m_acc <= 1'b0;
      m_sh_data <= '0; m_data <= '0; m_sh_dp <= '0; m_dp <= '0; m_br <= '0;
    end else begin
      m_acc <= i_wr_valid && !m_pend;
      if ((m_cyc % FRAME) == FRAME - 1 && m_pend) begin
        m_data <= m_sh_data; m_dp <= m_sh_dp; m_pend <= 1'b0;
      end else if (i_wr_valid && !m_pend) begin
        m_sh_data <= i_wr_data; m_sh_dp <= i_wr_dp; m_pend <= 1'b1;
      end
      if ((m_cyc % SLOT) == SLOT - 1) m_br <= i_bright;
      m_cyc <= m_cyc + 1;
    end
  end

  function automatic logic [9:0] obs();
    return {o_wr_ready, o_val, o_dec, o_blank, o_dig_en, o_frame};
  endfunction

  function automatic logic [9:0] exp_out();
    int dc, dg;
    logic [3:0] nib;
    logic dp, lzb_blk, bl;
    logic [1:0] en;
    dc  = m_cyc % SLOT;
    dg  = (m_cyc / SLOT) % ND;
    nib = 4'((m_data >> (4 * dg)) & 8'hF);
    dp  = m_dp[dg];
    lzb_blk = i_lzb && (dg != 0);
    for (int k = dg; k < ND; k++)
      if ((((m_data >> (4 * k)) & 8'hF) != 0) || m_dp[k]) lzb_blk = 1'b0;
    en = '0;
    bl = 1'b1;
    if (dc >= DEAD && !lzb_blk && (((dc - DEAD) / STEP) < int'(m_br))) begin
      en = 2'(1 << dg);
      bl = 1'b0;
    end
    return {!m_pend, nib, dp, bl, en, (m_cyc % FRAME) == FRAME - 1};
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    i_wr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    i_wr_valid = 1'b1;
    i_wr_data  = 8'($urandom);
    i_wr_dp    = 2'($urandom);
    i_bright   = 2'd3;
    i_rst_n    = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (obs() !== RESET_VEC) begin
        errors++;
        $display("FAIL reset_values i=%0d got=%b exp=%b", i, obs(), RESET_VEC);
      end
      checks++;
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL reset_model i=%0d got=%b exp=%b", i, obs(), exp_out());
      end
      checks++;
      next_cycle();
    end
    i_wr_valid = 1'b0;
  endtask

  task automatic test_brightness();
    int lit_cnt;
    i_bright = 2'd3; i_lzb = 1'b0;
    apply_reset();
    lit_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL bright_model cyc=%0d got=%b exp=%b", i, obs(), exp_out());
      end
      checks++;
      if (o_frame !== (i == 19 || i == 39)) begin
        errors++;
        $display("FAIL bright_frame cyc=%0d got=%b", i, o_frame);
      end
      checks++;
      if (o_dig_en != '0) lit_cnt++;
      if (i % 10 == 9) begin
        if (lit_cnt != ((i == 9) ? 0 : 6)) begin
          errors++;
          $display("FAIL bright_duty slot=%0d got=%0d exp=%0d", i / 10, lit_cnt, (i == 9) ? 0 : 6);
        end
        checks++;
        lit_cnt = 0;
      end
      next_cycle();
    end
  endtask

  task automatic test_write();
    logic exp_rdy;
    logic [3:0] exp_val;
    i_bright = 2'd3; i_lzb = 1'b0;
    apply_reset();
    i_wr_data = 8'h47; i_wr_dp = 2'b00;
    for (int i = 0; i < 40; i++) begin
      exp_rdy = !(i >= 6 && i <= 19);
      exp_val = (i < 20) ? 4'd0 : ((i < 30) ? 4'd7 : 4'd4);
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL write_model cyc=%0d got=%b exp=%b", i, obs(), exp_out());
      end
      checks++;
      if (o_wr_ready !== exp_rdy || o_val !== exp_val) begin
        errors++;
        $display("FAIL write_directed cyc=%0d got rdy=%b val=%h exp rdy=%b val=%h",
                 i, o_wr_ready, o_val, exp_rdy, exp_val);
      end
      checks++;
      if (m_acc) i_wr_valid = 1'b0;
      if (i == 5) i_wr_valid = 1'b1;
      next_cycle();
    end
  endtask

  task automatic test_frame_accept();
    logic [7:0] dat;
    logic [3:0] exp_val;
    dat = {4'($urandom_range(1, 9)), 4'($urandom_range(1, 9))};
    i_bright = 2'd2; i_lzb = 1'b0;
    apply_reset();
    i_wr_data = dat; i_wr_dp = 2'b01;
    for (int i = 0; i < 60; i++) begin
      exp_val = (i < 40) ? 4'd0 : ((i < 50) ? dat[3:0] : dat[7:4]);
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL frame_acc_model cyc=%0d got=%b exp=%b", i, obs(), exp_out());
      end
      checks++;
      if (o_val !== exp_val || o_wr_ready !== !(i >= 20 && i <= 39)) begin
        errors++;
        $display("FAIL frame_acc_directed cyc=%0d got val=%h rdy=%b exp val=%h", i, o_val, o_wr_ready, exp_val);
      end
      checks++;
      if (m_acc) i_wr_valid = 1'b0;
      if (i == 19) i_wr_valid = 1'b1;
      next_cycle();
    end
  endtask

  task automatic test_lzb();
    int lit_cnt;
    int exp_lit[8] = '{0, 0, 6, 0, 6, 6, 6, 0};
    i_bright = 2'd3; i_lzb = 1'b1;
    apply_reset();
    lit_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL lzb_model cyc=%0d got=%b exp=%b", i, obs(), exp_out());
      end
      checks++;
      if ((i / 10 == 3 || i / 10 == 7) && {o_blank, o_dig_en} !== 3'b100) begin
        errors++;
        $display("FAIL lzb_blanked cyc=%0d got blank=%b en=%b", i, o_blank, o_dig_en);
      end
      if (i / 10 == 5 && {o_val, o_dec} !== 5'b0000_1) begin
        errors++;
        $display("FAIL lzb_dp_digit cyc=%0d got val=%h dec=%b", i, o_val, o_dec);
      end
      if (o_dig_en != '0) lit_cnt++;
      if (i % 10 == 9) begin
        if (lit_cnt != exp_lit[i / 10]) begin
          errors++;
          $display("FAIL lzb_lit slot=%0d got=%0d exp=%0d", i / 10, lit_cnt, exp_lit[i / 10]);
        end
        checks++;
        lit_cnt = 0;
      end
      if (m_acc) i_wr_valid = 1'b0;
      if (i == 0)  begin i_wr_data = 8'h05; i_wr_dp = 2'b00; i_wr_valid = 1'b1; end
      if (i == 20) begin i_wr_data = 8'h05; i_wr_dp = 2'b10; i_wr_valid = 1'b1; end
      if (i == 40) begin i_wr_data = 8'h00; i_wr_dp = 2'b00; i_wr_valid = 1'b1; end
      next_cycle();
    end
    i_lzb = 1'b0;
  endtask

  task automatic test_bright_change();
    int lit_cnt;
    int exp_lit[7] = '{0, 0, 0, 0, 0, 2, 4};
    i_bright = 2'd0; i_lzb = 1'b0;
    apply_reset();
    lit_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL bchg_model cyc=%0d got=%b exp=%b", i, obs(), exp_out());
      end
      checks++;
      if (i < 40 && {o_blank, o_dig_en} !== 3'b100) begin
        errors++;
        $display("FAIL bchg_dark cyc=%0d got blank=%b en=%b", i, o_blank, o_dig_en);
      end
      if (o_dig_en != '0) lit_cnt++;
      if (i % 10 == 9) begin
        if (lit_cnt != exp_lit[i / 10]) begin
          errors++;
          $display("FAIL bchg_lit slot=%0d got=%0d exp=%0d", i / 10, lit_cnt, exp_lit[i / 10]);
        end
        checks++;
        lit_cnt = 0;
      end
      if (i == 44) i_bright = 2'd1;
      if (i == 53) i_bright = 2'd2;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    i_bright = 2'd3; i_lzb = 1'b0;
    apply_reset();
    for (int i = 0; i < 35; i++) begin
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL rmid_model cyc=%0d got=%b exp=%b", i, obs(), exp_out());
      end
      checks++;
      if (i == 34) break;
      if (m_acc) i_wr_valid = 1'b0;
      if (i == 0)  begin i_wr_data = {4'($urandom_range(1, 9)), 4'($urandom_range(1, 9))}; i_wr_valid = 1'b1; end
      if (i == 20) begin i_wr_data = {4'($urandom_range(1, 9)), 4'($urandom_range(1, 9))}; i_wr_valid = 1'b1; end
      next_cycle();
    end
    if (o_wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_pending got rdy=%b exp=0", o_wr_ready);
    end
    checks++;
    i_rst_n = 1'b0;
    #1;
    if (obs() !== RESET_VEC) begin
      errors++;
      $display("FAIL rmid_async got=%b exp=%b", obs(), RESET_VEC);
    end
    checks++;
    @(negedge clk);
    i_rst_n = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (obs() !== exp_out() || o_val !== 4'd0 || o_wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL rmid_after cyc=%0d got=%b exp=%b", i, obs(), exp_out());
      end
      checks++;
      next_cycle();
    end
  endtask

  task automatic test_random();
    i_lzb = 1'b0; i_bright = 2'($urandom);
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", i, obs(), exp_out());
      end
      checks++;
      if (m_acc) i_wr_valid = 1'b0;
      if ($urandom_range(0, 15) == 0) i_bright = 2'($urandom);
      if ($urandom_range(0, 31) == 0) i_lzb = ~i_lzb;
      if (!i_wr_valid && $urandom_range(0, 11) == 0) begin
        for (int k = 0; k < ND; k++)
          i_wr_data[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        i_wr_dp    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
        i_wr_valid = 1'b1;
      end
      next_cycle();
    end
    i_wr_valid = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_wr_valid = 1'b0; i_wr_data = '0; i_wr_dp = '0;
    i_lzb = 1'b0; i_bright = '0;
    test_reset();
    test_brightness();
    test_write();
    test_frame_accept();
    test_lzb();
    test_bright_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
